// File: rtl/uart_tx_pkg.sv
// Shared UART types: frame-format enums, the configuration struct and small helpers.
// Imported by the transmitter and the receiver alike.
package common;

  localparam int DIVISOR_W = 25;

  typedef enum logic [1:0] {
    DATA_FIVE  = 2'b00,
    DATA_SIX   = 2'b01,
    DATA_SEVEN = 2'b10,
    DATA_EIGHT = 2'b11
  } data_bits_e;

  // 2'b11 is reserved and treated exactly like PARITY_NONE.
  typedef enum logic [1:0] {
    PARITY_NONE = 2'b00,
    PARITY_ODD  = 2'b01,
    PARITY_EVEN = 2'b10,
    PARITY_RSVD = 2'b11
  } parity_e;

  typedef enum logic {
    STOP_ONE = 1'b0,
    STOP_TWO = 1'b1
  } stop_e;

  typedef enum logic {
    FLOW_NONE    = 1'b0,
    FLOW_RTS_CTS = 1'b1
  } flow_e;

  typedef struct packed {
    data_bits_e           data_bits;
    parity_e              parity;
    stop_e                stop;
    flow_e                flow;
    logic [DIVISOR_W-1:0] divisor;
  } uart_config_t;

  function automatic logic [DIVISOR_W-1:0] bit_period(input logic [DIVISOR_W-1:0] divisor);
    return (divisor == '0) ? DIVISOR_W'(1) : divisor;
  endfunction

  function automatic logic [7:0] data_mask(input data_bits_e bits);
    logic [7:0] mask;
    case (bits)
      DATA_FIVE:  mask = 8'h1F;
      DATA_SIX:   mask = 8'h3F;
      DATA_SEVEN: mask = 8'h7F;
      default:    mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic parity_enabled(input parity_e p);
    return (p == PARITY_ODD) || (p == PARITY_EVEN);
  endfunction

  function automatic logic parity_bit(input logic [7:0] masked, input parity_e p);
    return (^masked) ^ (p == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side byte handshake of the UART transmitter (valid/ready with an 8-bit payload).
interface uart_tx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (output data, output data_valid, input data_ready);
  modport slave  (input data, input data_valid, output data_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle tick every max(divisor,1) clocks, realigned by restart.
// Shared between the UART transmitter and receiver.
module uart_baud_gen
  import common::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DIVISOR_W-1:0] divisor,
  input  logic                 restart,
  output logic                 tick
);

  localparam logic [DIVISOR_W-1:0] ONE = DIVISOR_W'(1);

  logic [DIVISOR_W-1:0] count_reg;
  logic [DIVISOR_W-1:0] count_next;

  // Reloading at zero (rather than decrementing) keeps the counter from ever wrapping.
  always_comb begin
    tick       = (count_reg == '0) && !restart;
    count_next = count_reg - ONE;
    if (restart || (count_reg == '0)) begin
      count_next = bit_period(divisor) - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, configurable 5-8 data bits, parity, 1/2 stop bits.
// Optional CTS flow control is compiled in only when UART_TX_FLOW_EN is defined.
module uart_tx
  import common::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  uart_config_t config_i,
  input  logic [7:0]   data_i,
  input  logic         data_valid_i,
  output logic         data_ready_o,
  input  logic         cts_i,
  output logic         txd_o,
  output logic         busy_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [7:0]           shift_reg, shift_next;
  logic [2:0]           bit_cnt_reg, bit_cnt_next;
  data_bits_e           data_bits_reg, data_bits_next;
  logic                 parity_en_reg, parity_en_next;
  logic                 parity_val_reg, parity_val_next;
  logic                 stop_two_reg, stop_two_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic [DIVISOR_W-1:0] divisor_reg, divisor_next;
  logic                 txd_reg, txd_next;
  logic                 busy_reg, busy_next;
  logic                 ready_reg, ready_next;

  logic                 accept;
  logic                 cts_ok;
  logic                 tick;
  logic [7:0]           masked_data;
  logic [2:0]           last_bit;
  logic [DIVISOR_W-1:0] baud_divisor;

`ifdef UART_TX_FLOW_EN
  assign cts_ok = (config_i.flow != FLOW_RTS_CTS) || cts_i;
`else
  logic unused_flow;
  assign cts_ok      = 1'b1;
  assign unused_flow = ^{cts_i, config_i.flow};
`endif

  assign accept       = data_valid_i && ready_reg;
  assign masked_data  = data_i & data_mask(config_i.data_bits);
  assign last_bit     = 3'd4 + {1'b0, data_bits_reg};
  // The first bit period must already use the divisor being latched this cycle.
  assign baud_divisor = accept ? config_i.divisor : divisor_reg;

  uart_baud_gen u_baud_gen (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .divisor (baud_divisor),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    data_bits_next  = data_bits_reg;
    parity_en_next  = parity_en_reg;
    parity_val_next = parity_val_reg;
    stop_two_next   = stop_two_reg;
    stop_cnt_next   = stop_cnt_reg;
    divisor_next    = divisor_reg;
    txd_next        = txd_reg;

    case (state_reg)
      ST_IDLE: begin
        txd_next = 1'b1;
        if (accept) begin
          shift_next      = masked_data;
          data_bits_next  = config_i.data_bits;
          parity_en_next  = parity_enabled(config_i.parity);
          parity_val_next = parity_bit(masked_data, config_i.parity);
          stop_two_next   = (config_i.stop == STOP_TWO);
          divisor_next    = config_i.divisor;
          bit_cnt_next    = 3'd0;
          txd_next        = 1'b0;
          state_next      = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          txd_next     = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = 3'd0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_reg == last_bit) begin
            if (parity_en_reg) begin
              txd_next   = parity_val_reg;
              state_next = ST_PARITY;
            end else begin
              txd_next      = 1'b1;
              stop_cnt_next = 1'b0;
              state_next    = ST_STOP;
            end
          end else begin
            txd_next     = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          txd_next      = 1'b1;
          stop_cnt_next = 1'b0;
          state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          txd_next = 1'b1;
          if (stop_two_reg && !stop_cnt_reg) begin
            stop_cnt_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        txd_next   = 1'b1;
        state_next = ST_IDLE;
      end
    endcase

    busy_next  = (state_next != ST_IDLE);
    ready_next = (state_next == ST_IDLE) && cts_ok;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      data_bits_reg  <= DATA_EIGHT;
      parity_en_reg  <= 1'b0;
      parity_val_reg <= 1'b0;
      stop_two_reg   <= 1'b0;
      stop_cnt_reg   <= 1'b0;
      divisor_reg    <= '0;
      txd_reg        <= 1'b1;
      busy_reg       <= 1'b0;
      ready_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      data_bits_reg  <= data_bits_next;
      parity_en_reg  <= parity_en_next;
      parity_val_reg <= parity_val_next;
      stop_two_reg   <= stop_two_next;
      stop_cnt_reg   <= stop_cnt_next;
      divisor_reg    <= divisor_next;
      txd_reg        <= txd_next;
      busy_reg       <= busy_next;
      ready_reg      <= ready_next;
    end
  end

  assign txd_o        = txd_reg;
  assign busy_o       = busy_reg;
  assign data_ready_o = ready_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms come from a bit-list frame model.
// Covers the CTS path when built with UART_TX_FLOW_EN, and checks CTS is ignored otherwise.
module tb_uart_tx;
  import common::*;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  uart_config_t cfg_in;
  logic         cts_i = 1'b1;
  logic         txd_o;
  logic         busy_o;
  int           errors = 0;
  int           checks = 0;

  uart_tx_if u_if();

  uart_tx dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .config_i     (cfg_in),
    .data_i       (u_if.data),
    .data_valid_i (u_if.data_valid),
    .data_ready_o (u_if.data_ready),
    .cts_i        (cts_i),
    .txd_o        (txd_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic uart_config_t make_cfg(input int db, input int par, input int stp, input int div);
    uart_config_t c;
    c.data_bits = data_bits_e'(db);
    c.parity    = parity_e'(par);
    c.stop      = stop_e'(stp);
    c.flow      = FLOW_NONE;
    c.divisor   = DIVISOR_W'(div);
    return c;
  endfunction

  // Frame as a list of line levels, one entry per bit: start, data LSB first, parity, stops.
  task automatic model_frame(input logic [7:0] d, input uart_config_t c,
                             output int nb, output logic [11:0] bits);
    int n;
    int ones;
    n    = 5 + int'(c.data_bits);
    bits = '1;
    bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      bits[1 + i] = d[i];
      ones += int'(d[i]);
    end
    nb = 1 + n;
    if (c.parity == PARITY_EVEN) begin
      bits[nb] = (ones % 2 == 1);
      nb++;
    end else if (c.parity == PARITY_ODD) begin
      bits[nb] = (ones % 2 == 0);
      nb++;
    end
    nb += (c.stop == STOP_TWO) ? 2 : 1;
  endtask

  task automatic offer_byte(input logic [7:0] d, input bit hold, input logic [7:0] next_d);
    int waited = 0;
    while (u_if.data_ready !== 1'b1 && waited < 200) begin
      step();
      waited++;
    end
    checks++;
    if (u_if.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: data_ready_o=%b after %0d cycles, required 1", u_if.data_ready, waited);
    end
    u_if.data       = d;
    u_if.data_valid = 1'b1;
    step();
    if (hold) u_if.data = next_d;
    else      u_if.data_valid = 1'b0;
  endtask

  // Called on the first cycle after acceptance; returns on the idle-return cycle.
  task automatic monitor_frame(input logic [7:0] d, input uart_config_t c,
                               input string name, input logic idle_ready);
    int          nb;
    int          p;
    int          good;
    logic [11:0] bits;
    model_frame(d, c, nb, bits);
    p = (c.divisor == 0) ? 1 : int'(c.divisor);
    for (int b = 0; b < nb; b++) begin
      good = 0;
      for (int k = 0; k < p; k++) begin
        if (txd_o === bits[b] && busy_o === 1'b1 && u_if.data_ready === 1'b0) good++;
        step();
      end
      checks++;
      if (good !== p) begin
        errors++;
        $display("FAIL %s bit%0d: level %b held correctly %0d clocks, required %0d", name, b, bits[b], good, p);
      end
    end
    checks++;
    if ({txd_o, busy_o, u_if.data_ready} !== {1'b1, 1'b0, idle_ready}) begin
      errors++;
      $display("FAIL %s idle: txd/busy/ready=%b%b%b required 10%b", name, txd_o, busy_o, u_if.data_ready, idle_ready);
    end
    $display("frame %s data=%02h bits=%0d period=%0d done", name, d, nb, p);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if ({txd_o, busy_o, u_if.data_ready} !== 3'b100) begin
        errors++;
        $display("FAIL reset_hold: txd/busy/ready=%b%b%b required 100", txd_o, busy_o, u_if.data_ready);
      end
    end
    reset_i = 1'b0;
    step();
    checks++;
    if (u_if.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: data_ready_o=%b required 1", u_if.data_ready);
    end
  endtask

  task automatic test_8n1();
    cfg_in = make_cfg(3, 0, 0, 4);
    offer_byte(8'hA5, 1'b0, 8'h00);
    monitor_frame(8'hA5, cfg_in, "8n1_a5", 1'b1);
  endtask

  task automatic test_parity();
    uart_config_t c;
    c = make_cfg(2, 2, 0, 2);
    cfg_in = c;
    offer_byte(8'h55, 1'b0, 8'h00);
    monitor_frame(8'h55, c, "7e1_55", 1'b1);
    c = make_cfg(2, 1, 0, 2);
    cfg_in = c;
    offer_byte(8'h55, 1'b0, 8'h00);
    monitor_frame(8'h55, c, "7o1_55", 1'b1);
    c = make_cfg(0, 3, 0, 3);
    cfg_in = c;
    offer_byte(8'hFF, 1'b0, 8'h00);
    monitor_frame(8'hFF, c, "5rsvd_ff", 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    a = 8'($urandom);
    b = 8'($urandom);
    cfg_in = make_cfg(3, 0, 1, 3);
    offer_byte(a, 1'b1, b);
    monitor_frame(a, cfg_in, "b2b_first", 1'b1);
    step();
    u_if.data_valid = 1'b0;
    monitor_frame(b, cfg_in, "b2b_second", 1'b1);
  endtask

  task automatic test_divisor_change();
    uart_config_t c;
    c = make_cfg(3, 0, 0, 4);
    cfg_in = c;
    offer_byte(8'h3C, 1'b0, 8'h00);
    cfg_in.divisor = 25'd8;
    cfg_in.parity  = PARITY_EVEN;
    monitor_frame(8'h3C, c, "div_old", 1'b1);
    offer_byte(8'hC3, 1'b0, 8'h00);
    monitor_frame(8'hC3, cfg_in, "div_new", 1'b1);
    for (int dv = 0; dv < 2; dv++) begin
      cfg_in = make_cfg(1, 0, 0, dv);
      offer_byte(8'h2D, 1'b0, 8'h00);
      monitor_frame(8'h2D, cfg_in, "div_min", 1'b1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'($urandom);
    cfg_in = make_cfg(3, 0, 0, 4);
    offer_byte(d, 1'b0, 8'h00);
    repeat (17) step();
    checks++;
    if ({txd_o, busy_o} !== {d[3], 1'b1}) begin
      errors++;
      $display("FAIL mid_bit3: txd/busy=%b%b required %b1", txd_o, busy_o, d[3]);
    end
    reset_i = 1'b1;
    step();
    checks++;
    if ({txd_o, busy_o, u_if.data_ready} !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset: txd/busy/ready=%b%b%b required 100", txd_o, busy_o, u_if.data_ready);
    end
    reset_i = 1'b0;
    step();
    checks++;
    if ({txd_o, busy_o, u_if.data_ready} !== 3'b101) begin
      errors++;
      $display("FAIL mid_release: txd/busy/ready=%b%b%b required 101", txd_o, busy_o, u_if.data_ready);
    end
  endtask

  task automatic test_flow();
    uart_config_t c;
    c = make_cfg(3, 0, 0, 2);
    c.flow = FLOW_RTS_CTS;
    cfg_in = c;
`ifdef UART_TX_FLOW_EN
    begin
      int bad;
      cts_i = 1'b0;
      step();
      u_if.data       = 8'h96;
      u_if.data_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (txd_o !== 1'b1 || busy_o !== 1'b0 || u_if.data_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL cts_blocked: %0d cycles active with cts low, required 0", bad);
      end
      cts_i = 1'b1;
      step();
      checks++;
      if ({txd_o, u_if.data_ready} !== 2'b11) begin
        errors++;
        $display("FAIL cts_raise: txd/ready=%b%b required 11", txd_o, u_if.data_ready);
      end
      step();
      u_if.data_valid = 1'b0;
      cts_i = 1'b0;
      monitor_frame(8'h96, c, "cts_frame", 1'b0);
      cts_i = 1'b1;
      step();
    end
`else
    cts_i = 1'b0;
    offer_byte(8'h96, 1'b0, 8'h00);
    monitor_frame(8'h96, c, "cts_ignored", 1'b1);
    cts_i = 1'b1;
`endif
  endtask

  task automatic test_random();
    uart_config_t c;
    logic [7:0]   d;
    for (int n = 0; n < 20; n++) begin
      c = make_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      c.flow = flow_e'($urandom_range(0, 1));
      d = 8'($urandom);
      cfg_in = c;
      offer_byte(d, 1'b0, 8'h00);
      cfg_in = make_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
      monitor_frame(d, c, "random", 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  initial begin
    u_if.data       = 8'h00;
    u_if.data_valid = 1'b0;
    cfg_in          = make_cfg(3, 0, 0, 4);
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_divisor_change();
    test_reset_midframe();
    test_flow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
